// File: rtl/timer_pkg.sv
// Shared constants for the clock/timer display counter channels.
package timer_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int SEC_MOD  = 60;
  localparam int MIN_MOD  = 60;
  localparam int HOUR_MOD = 24;

endpackage

// File: rtl/btn_sync_edge.sv
// Synchronises an asynchronous button level and emits one pulse per rising edge.
module btn_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic pulse_out
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], async_in};
    prev_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  // Combinational pulse so the counter updates exactly STAGES edges after first sample.
  assign pulse_out = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/mod_updown_counter.sv
// Modulo-N up/down counter channel: tick-driven run mode, button-driven adjust mode.
module mod_updown_counter
  import timer_pkg::*;
#(
  parameter int WIDTH       = 6,
  parameter int MODULUS     = 60,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             forward,
  input  logic             tick,
  input  logic             inc_btn,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] value,
  output logic             carry,
  output logic             finish,
  output logic             at_zero
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);

  logic [WIDTH-1:0] value_q, value_d;
  logic             carry_q, carry_d;
  logic             finish_q, finish_d;
  logic             inc_pulse;

  btn_sync_edge #(
    .STAGES(SYNC_STAGES)
  ) u_btn (
    .clk      (clk),
    .reset    (reset),
    .async_in (inc_btn),
    .pulse_out(inc_pulse)
  );

  always_comb begin
    value_d  = value_q;
    carry_d  = 1'b0;
    finish_d = finish_q;
    if (clear) begin
      value_d  = '0;
      finish_d = 1'b0;
    end else if (load) begin
      value_d  = ({1'b0, load_val} < MOD_EXT) ? load_val : MAX_VAL;
      finish_d = 1'b0;
    end else if (enable) begin
      if (tick) begin
        if (forward == DIR_UP) begin
          if (value_q == MAX_VAL) begin
            value_d = '0;
            carry_d = 1'b1;
          end else begin
            value_d = value_q + 1'b1;
          end
        end else begin
          // Down-count at zero holds the value and latches finish.
          if (value_q == '0) begin
            finish_d = 1'b1;
          end else begin
            value_d = value_q - 1'b1;
          end
        end
      end
    end else if (inc_pulse) begin
      value_d  = (value_q == MAX_VAL) ? '0 : value_q + 1'b1;
      finish_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      value_q  <= '0;
      carry_q  <= 1'b0;
      finish_q <= 1'b0;
    end else begin
      value_q  <= value_d;
      carry_q  <= carry_d;
      finish_q <= finish_d;
    end
  end

  assign value   = value_q;
  assign carry   = carry_q;
  assign finish  = finish_q;
  assign at_zero = (value_q == '0);

endmodule

// File: tb/tb_mod_updown_counter.sv
// Randomised and directed check of two counter channels (mod 60 and mod 24) against a behavioural model.
module tb_mod_updown_counter;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1, enable = 1'b1, forward = 1'b1, tick = 1'b0;
  logic       inc_btn = 1'b0, clear = 1'b0, load = 1'b0;
  logic [5:0] lv0 = '0;
  logic [4:0] lv1;
  logic [5:0] value0;
  logic [4:0] value1;
  logic       carry0, finish0, at_zero0, carry1, finish1, at_zero1;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;
  int carries1;

  assign lv1 = lv0[4:0];

  always #5 clk = ~clk;

  mod_updown_counter #(.WIDTH(6), .MODULUS(60), .SYNC_STAGES(S)) u0 (
    .clk(clk), .reset(reset), .enable(enable), .forward(forward), .tick(tick),
    .inc_btn(inc_btn), .clear(clear), .load(load), .load_val(lv0),
    .value(value0), .carry(carry0), .finish(finish0), .at_zero(at_zero0)
  );

  mod_updown_counter #(.WIDTH(5), .MODULUS(24), .SYNC_STAGES(S)) u1 (
    .clk(clk), .reset(reset), .enable(enable), .forward(forward), .tick(tick),
    .inc_btn(inc_btn), .clear(clear), .load(load), .load_val(lv1),
    .value(value1), .carry(carry1), .finish(finish1), .at_zero(at_zero1)
  );

  // Model: count value as a plain integer, button as a history of sampled levels.
  typedef struct packed {
    logic [31:0] val;
    logic        carry;
    logic        fin;
    logic [S:0]  hist;
  } mdl_t;

  mdl_t m0 = '0;
  mdl_t m1 = '0;

  function automatic mdl_t mstep(mdl_t s, int m, int lv, logic rst, logic en, logic fw,
                                 logic tk, logic btn, logic clr, logic ld);
    mdl_t n = s;
    int v = int'(s.val);
    logic press = s.hist[S-1] & ~s.hist[S];
    n.carry = 1'b0;
    if (rst) begin
      n.val = 0; n.fin = 1'b0; n.hist = '0;
      return n;
    end
    n.hist = {s.hist[S-1:0], btn};
    if (clr) begin
      v = 0; n.fin = 1'b0;
    end else if (ld) begin
      v = (lv < m) ? lv : m - 1; n.fin = 1'b0;
    end else if (en && tk) begin
      if (fw) begin
        n.carry = (v + 1 == m);
        v = (v + 1) % m;
      end else if (v == 0) begin
        n.fin = 1'b1;
      end else begin
        v = v - 1;
      end
    end else if (!en && press) begin
      v = (v + 1) % m; n.fin = 1'b0;
    end
    n.val = 32'(v);
    return n;
  endfunction

  always @(posedge clk) begin
    m0 <= mstep(m0, 60, int'(lv0), reset, enable, forward, tick, inc_btn, clear, load);
    m1 <= mstep(m1, 24, int'(lv1), reset, enable, forward, tick, inc_btn, clear, load);
    if (!reset && carry1) carries1 <= carries1 + 1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      total = total + 1;
      if (int'(value0) != int'(m0.val) || carry0 !== m0.carry || finish0 !== m0.fin ||
          at_zero0 !== (m0.val == 0)) begin
        bad = bad + 1;
        $display("FAIL model60 t=%0t: got v=%0d c=%0b f=%0b z=%0b want v=%0d c=%0b f=%0b z=%0b",
                 $time, value0, carry0, finish0, at_zero0, m0.val, m0.carry, m0.fin, m0.val == 0);
      end
      total = total + 1;
      if (int'(value1) != int'(m1.val) || carry1 !== m1.carry || finish1 !== m1.fin ||
          at_zero1 !== (m1.val == 0)) begin
        bad = bad + 1;
        $display("FAIL model24 t=%0t: got v=%0d c=%0b f=%0b z=%0b want v=%0d c=%0b f=%0b z=%0b",
                 $time, value1, carry1, finish1, at_zero1, m1.val, m1.carry, m1.fin, m1.val == 0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input int act, input int exp);
    total = total + 1;
    if (act != exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  initial begin
    step(); step();
    chk_en = 1'b1;
    lit("reset_value", int'(value0), 0);
    lit("reset_carry", int'(carry0), 0);
    lit("reset_finish", int'(finish0), 0);
    lit("reset_at_zero", int'(at_zero0), 1);
    reset = 1'b0;

    // Wrap and carry
    enable = 1'b1; forward = 1'b1; load = 1'b1; lv0 = 6'd58; step();
    lit("load58", int'(value0), 58);
    lit("load58_sat24", int'(value1), 23);
    load = 1'b0; tick = 1'b1; step();
    lit("tick_59", int'(value0), 59);
    lit("no_carry_59", int'(carry0), 0);
    step();
    lit("wrap_0", int'(value0), 0);
    lit("wrap_carry", int'(carry0), 1);
    tick = 1'b0; step();
    lit("carry_one_cycle", int'(carry0), 0);
    tick = 1'b1; step(); step(); step(); tick = 1'b0;
    lit("tick_held3", int'(value0), 3);

    // Countdown and finish
    forward = 1'b0; load = 1'b1; lv0 = 6'd2; step(); load = 1'b0;
    tick = 1'b1; step();
    lit("down_1", int'(value0), 1);
    step();
    lit("down_0", int'(value0), 0);
    lit("down_0_finish", int'(finish0), 0);
    lit("down_0_at_zero", int'(at_zero0), 1);
    step();
    lit("finish_set", int'(finish0), 1);
    step();
    lit("finish_sticky", int'(finish0), 1);
    lit("hold_0", int'(value0), 0);
    tick = 1'b0; clear = 1'b1; step(); clear = 1'b0;
    lit("clear_finish", int'(finish0), 0);

    // Button in adjust mode
    enable = 1'b0; load = 1'b1; lv0 = 6'd59; step(); load = 1'b0;
    inc_btn = 1'b1;
    step();
    lit("btn_k", int'(value0), 59);
    step();
    lit("btn_k1", int'(value0), 59);
    step();
    lit("btn_k2", int'(value0), 0);
    lit("btn_no_carry", int'(carry0), 0);
    for (int i = 0; i < 17; i++) step();
    lit("btn_single", int'(value0), 0);
    inc_btn = 1'b0; step(); step(); step(); step();
    enable = 1'b1;
    inc_btn = 1'b1;
    for (int i = 0; i < 20; i++) step();
    lit("btn_run_ignored", int'(value0), 0);
    inc_btn = 1'b0; step(); step(); step(); step();

    // Load saturation and priority
    load = 1'b1; lv0 = 6'd63; step();
    lit("load_sat", int'(value0), 59);
    clear = 1'b1; lv0 = 6'd10; step(); clear = 1'b0;
    lit("clear_over_load", int'(value0), 0);
    reset = 1'b1; step(); reset = 1'b0; load = 1'b0;
    lit("reset_over_load", int'(value0), 0);

    // Reset mid-operation with finish set
    forward = 1'b0; tick = 1'b1; step(); tick = 1'b0;
    lit("pre_finish", int'(finish0), 1);
    forward = 1'b1; tick = 1'b1;
    for (int i = 0; i < 30; i++) step();
    tick = 1'b0; forward = 1'b0;
    lit("fwd_keeps_finish", int'(finish0), 1);
    lit("at_30", int'(value0), 30);
    reset = 1'b1; tick = 1'b1; step(); reset = 1'b0;
    lit("rst_mid_value", int'(value0), 0);
    lit("rst_mid_finish", int'(finish0), 0);
    lit("rst_mid_carry", int'(carry0), 0);
    step();
    lit("post_rst_finish", int'(finish0), 1);
    tick = 1'b0;

    // Modulus-24 sweep
    clear = 1'b1; step(); clear = 1'b0;
    forward = 1'b1; carries1 = 0; tick = 1'b1;
    for (int i = 0; i < 30; i++) step();
    tick = 1'b0; step();
    lit("sweep24_value", int'(value1), 6);
    lit("sweep24_carries", carries1, 1);
    lit("sweep60_value", int'(value0), 30);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      reset   = ($urandom % 200) == 0;
      clear   = ($urandom % 60) == 0;
      load    = ($urandom % 30) == 0;
      lv0     = 6'($urandom % 64);
      if (($urandom % 40) == 0) enable = ~enable;
      if (($urandom % 30) == 0) forward = ~forward;
      tick    = ($urandom % 3) == 0;
      if (($urandom % 6) == 0) inc_btn = ~inc_btn;
      step();
    end
    reset = 1'b0; clear = 1'b0; load = 1'b0; tick = 1'b0;
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mod_updown_counter.md
Name: mod_updown_counter

Overview:
Parametrised modulo-N up/down counter channel for the VGA clock/timer display. It runs in the single system clock domain and is advanced by a one-cycle `tick` strobe from the prescaler, not by a derived clock. In forward mode it counts up with wrap-around and emits a carry for cascading (seconds→minutes→hours). In backward mode it counts down to zero and raises a sticky `finish`. A debounced push-button level is synchronised and edge-detected internally for manual time setting.

Parameters:
WIDTH, 6, bit width of value; must satisfy 2**WIDTH >= MODULUS
MODULUS, 60, count range 0..MODULUS-1
SYNC_STAGES, 2, synchroniser depth for inc_btn (>= 2)

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
enable  in  1  1 = run (counts on tick); 0 = adjust (counts on button)
forward  in  1  1 = count up; 0 = count down
tick  in  1  one-cycle count strobe (1 Hz from prescaler, or the carry of the lower channel)
inc_btn  in  1  asynchronous button level; rising edge = manual increment
clear  in  1  synchronous clear of value and finish
load  in  1  synchronous load of load_val
load_val  in  WIDTH  preset value
value  out  WIDTH  current count (registered)
carry  out  1  one-cycle pulse on up-count wrap MODULUS-1→0
finish  out  1  sticky: a down-count tick arrived while value was 0
at_zero  out  1  combinational: value == 0

Behaviour:
- Reset (synchronous): value=0, carry=0, finish=0, all synchroniser and edge flops=0.
- Update priority per cycle: reset > clear > load > run/adjust. carry defaults to 0 every cycle.
- clear: value←0; finish←0.
- load: value←load_val if load_val < MODULUS, else value←MODULUS-1; finish←0.
- Button path: inc_btn → SYNC_STAGES flops → prev flop. inc_pulse = sync_out & ~prev. If inc_btn is first sampled high at edge k, value updates at edge k+SYNC_STAGES. One pulse per press, whatever the hold length.
- Run mode (enable=1), on tick=1, forward=1:
  - value==MODULUS-1 → value←0, carry←1 for one cycle.
  - Otherwise value+1.
- Run mode, on tick=1, forward=0:
  - value==0 → value holds at 0, finish←1.
  - Otherwise value-1.
- Run mode ignores inc_pulse; the pulse is dropped, not queued.
- Adjust mode (enable=0), on inc_pulse:
  - value←(value==MODULUS-1) ? 0 : value+1.
  - carry is never asserted in adjust mode. finish←0.
- Adjust mode ignores tick.
- finish stays set until reset, clear, load, or an adjust increment. A forward-mode tick does not clear it.
- Changing forward or enable mid-count takes effect on the next qualifying event; value is preserved.
- tick held high for N cycles = N count events. The bench must treat the tick width as a contract.
- Arithmetic is done in WIDTH bits; no intermediate value ever reaches MODULUS.
- Button held high across reset release: exactly one inc_pulse occurs, SYNC_STAGES+1 cycles after release. This is the defined behaviour.
- at_zero is driven purely from the value register; it has no extra latency.

Decomposition:
- Shared package timer_pkg:
  - DIR_UP/DIR_DOWN constants for forward.
  - Default modulus constants: SEC_MOD=60, MIN_MOD=60, HOUR_MOD=24.
- Sub-module btn_sync_edge, parameter STAGES. Ports: clk, reset, async_in, pulse_out. It is reused by the other button-driven channels.
- Counter core stays in mod_updown_counter. Cascading is done at top level by wiring carry into the next channel's tick.

Test Plan:
- Wrap/carry: MODULUS=60, enable=1, forward=1, load 58, two ticks → value 59 then 0; carry high for exactly the cycle after the 0 update; tick held 3 cycles from 0 → value 3.
- Countdown/finish: forward=0, load 2, four ticks → values 1, 0, 0, 0; finish rises after the third tick and stays 1; at_zero=1 from the second tick onward; clear → finish=0.
- Button sync: enable=0, SYNC_STAGES=2, value 59, inc_btn high 20 cycles → exactly one increment, to 0, two edges after first sample; no carry. Same press with enable=1 → value unchanged.
- Load saturation/priority: load_val=63 with MODULUS=60 → value 59. load and clear together → value 0. reset together with load → value 0.
- Reset mid-operation: counting down at value 30 with finish=1, assert reset for one cycle while tick=1 → value 0, finish 0, carry 0; next tick (forward=0) sets finish.
- Parameter sweep: MODULUS=24, WIDTH=5, 30 forward ticks from 0 → value 6, exactly one carry pulse.
